sine_burst_ctrl: RTL
====================

# sine_burst_ctrl

Sequencer for the 16-bit sine lookup ROM in the CIC decimation test bench. Replaces free-running index stepping with a controlled burst: programmable start phase, phase step (frequency) and sample count, with a valid/ready stream into the decimator input. It drives the ROM address, gates the ROM data onto the stream, and reports progress, completion and configuration errors.

## Interface
- LENGTH, 1000: ROM depth in samples; addresses run 0..LENGTH-1.
- AW, 10: address / step / phase width; requires 2^AW >= LENGTH.
- DW, 16: sample width.
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request; honoured only in IDLE.
- stop  in  1  stop request; honoured only while busy.
- phase0  in  AW  first ROM address, latched at start.
- step  in  AW  address increment per sample, latched at start.
- burst_len  in  16  samples per burst, latched at start; 0 = continuous until stop.
- rom_addr  out  AW  ROM address (registered).
- rom_data  in  DW  ROM read data; ROM is registered, so data for address A is valid after the clk edge that samples A.
- sample  out  DW  = rom_data while sample_valid, else 0.
- sample_valid  out  1  stream valid.
- sample_ready  in  1  stream ready from decimator.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse on burst end (count reached or stop).
- cfg_err  out  1  one-cycle pulse when start is rejected.
- sample_count  out  16  samples accepted in current/last burst.

## Operation
- States: IDLE, FETCH, VALID.
- IDLE: start with phase0 < LENGTH and step < LENGTH -> latch config, rom_addr <= phase0, sample_count <= 0, clear stop_pend, -> FETCH. Start with either out of range -> cfg_err pulse, stay IDLE, no other output change.
- FETCH: exactly one cycle (ROM read latency); -> VALID.
- VALID: sample_valid = 1; rom_addr held, so sample stays stable until accepted. On sample_valid & sample_ready: sample_count += 1; rom_addr <= (rom_addr + step) wraps modulo LENGTH (if sum >= LENGTH subtract LENGTH; sum computed at AW+1 bits). Then -> IDLE with done pulse if (burst_len != 0 and new count == burst_len) or stop_pend or stop this cycle; else -> FETCH.
- stop: in FETCH, or in VALID without acceptance, sets stop_pend. The current sample is never dropped: the burst ends after it is accepted. stop in IDLE is ignored.
- start while busy: ignored. start and stop in the same IDLE cycle: start honoured, stop ignored.
- step = 0: legal; the constant sample rom[phase0] repeats.
- Continuous mode: sample_count wraps 65535 -> 0; the burst never self-terminates.
- sample_count holds its final value in IDLE until the next accepted start.
- rst: any state -> IDLE at that edge. rom_addr=0, sample_valid=0, sample=0, busy=0, done=0, cfg_err=0, sample_count=0, stop_pend=0. An in-flight sample is discarded.

## Timing
- Edge E0 samples start. After E0: FETCH, busy=1, rom_addr=phase0. After E1: VALID, sample_valid=1, sample=rom[phase0].
- Maximum throughput is one sample per 2 cycles (valid alternates with ready held high).
- Acceptance at edge Ek: the next valid is asserted after Ek+1.
- done is asserted for the cycle after the final acceptance edge, coincident with busy=0. A new start is accepted in that same cycle.
- cfg_err is asserted for the cycle after the rejecting edge.

## Test plan
- Reset/idle: rst high 3 cycles, then low -> all outputs 0. start with phase0=0, step=1, burst_len=4, ready=1 -> samples rom[0..3] on alternating cycles, valid first after 2 edges, done after the 4th, sample_count=4.
- Wrap: phase0=998, step=3, burst_len=3 -> rom_addr sequence 998, 1, 4; samples match the ROM at those addresses.
- Backpressure: ready low for 5 cycles while valid -> sample and rom_addr stable, count unchanged; ready high -> single acceptance.
- Stop: burst_len=0; assert stop in FETCH after the 10th acceptance -> the 11th sample is delivered, then done, sample_count=11. stop asserted in IDLE -> no effect.
- Config error: step=1000 or phase0=1023 -> cfg_err one-cycle pulse, busy stays 0. start while busy -> ignored; config remains unchanged.
- Reset mid-burst: rst while valid=1 -> next cycle everything 0, IDLE; a fresh start then behaves as in the first scenario.

Source files
------------

// File: rtl/sine_burst_ctrl.sv
// sine_burst_ctrl: burst sequencer for a registered sine lookup ROM.
// Steps the ROM address from a programmable start phase by a programmable
// step (wrapping modulo LENGTH), presents each ROM word on a valid/ready
// stream, and reports busy, completion, rejected starts and accepted count.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   start, stop         burst request (IDLE only) / stop request (busy only)
//   phase0, step        first address and per-sample increment, latched at start
//   burst_len           samples per burst, 0 = run until stop
//   rom_addr, rom_data  ROM address out (registered), ROM data in (1-cycle latency)
//   sample, sample_valid, sample_ready   output stream
//   busy, done, cfg_err, sample_count    status
module sine_burst_ctrl #(
    parameter int unsigned LENGTH = 1000,
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 16
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [AW-1:0] phase0,
    input  logic [AW-1:0] step,
    input  logic [15:0]   burst_len,
    output logic [AW-1:0] rom_addr,
    input  logic [DW-1:0] rom_data,
    output logic [DW-1:0] sample,
    output logic          sample_valid,
    input  logic          sample_ready,
    output logic          busy,
    output logic          done,
    output logic          cfg_err,
    output logic [15:0]   sample_count
);

    localparam int unsigned CW    = 16;
    localparam logic [AW:0] LEN_W = (AW+1)'(LENGTH);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FETCH = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] rom_addr_q,  rom_addr_d;
    logic [AW-1:0] step_q,      step_d;
    logic [CW-1:0] len_q,       len_d;
    logic [CW-1:0] count_q,     count_d;
    logic          stop_pend_q, stop_pend_d;
    logic          valid_q,     valid_d;
    logic          busy_q,      busy_d;
    logic          done_q,      done_d;
    logic          cfg_err_q,   cfg_err_d;

    logic [AW:0]   addr_sum;
    logic [AW-1:0] addr_next;
    logic [CW-1:0] count_inc;
    logic          cfg_ok;

    // Next address: sum at AW+1 bits so the carry is visible, then fold once.
    assign addr_sum  = {1'b0, rom_addr_q} + {1'b0, step_q};
    assign addr_next = AW'((addr_sum >= LEN_W) ? (addr_sum - LEN_W) : addr_sum);
    assign count_inc = count_q + CW'(1);
    assign cfg_ok    = ({1'b0, phase0} < LEN_W) && ({1'b0, step} < LEN_W);

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        rom_addr_d  = rom_addr_q;
        step_d      = step_q;
        len_d       = len_q;
        count_d     = count_q;
        stop_pend_d = stop_pend_q;
        done_d      = 1'b0;
        cfg_err_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (cfg_ok) begin
                        step_d      = step;
                        len_d       = burst_len;
                        rom_addr_d  = phase0;
                        count_d     = '0;
                        stop_pend_d = 1'b0;
                        state_d     = FETCH;
                    end else begin
                        cfg_err_d   = 1'b1;
                    end
                end
            end
            FETCH: begin
                if (stop) stop_pend_d = 1'b1;
                state_d = VALID;
            end
            VALID: begin
                if (sample_ready) begin
                    count_d    = count_inc;
                    rom_addr_d = addr_next;
                    if (((len_q != '0) && (count_inc == len_q)) || stop_pend_q || stop) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = FETCH;
                    end
                end else if (stop) begin
                    // Current sample is still owed; finish after its acceptance.
                    stop_pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        valid_d = (state_d == VALID);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rom_addr_q  <= '0;
            step_q      <= '0;
            len_q       <= '0;
            count_q     <= '0;
            stop_pend_q <= 1'b0;
            valid_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rom_addr_q  <= rom_addr_d;
            step_q      <= step_d;
            len_q       <= len_d;
            count_q     <= count_d;
            stop_pend_q <= stop_pend_d;
            valid_q     <= valid_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // ROM word is gated onto the stream only while valid.
    assign sample       = valid_q ? rom_data : '0;
    assign rom_addr     = rom_addr_q;
    assign sample_valid = valid_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign cfg_err      = cfg_err_q;
    assign sample_count = count_q;

endmodule
